// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin merge of icache/dcache line requests onto one memory port
// One transaction in flight; the response is routed back to the cache that won arbitration.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_rw,
  input  logic [DATA_W-1:0] ic_req_wdata,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_rw,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_rw,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              err_spurious
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic SRC_IC = 1'b0;
  localparam logic SRC_DC = 1'b1;

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic [DATA_W-1:0] resp_data;
  logic              grant_ic;
  logic              grant_dc;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    grant_dc = dc_req_valid && (!ic_req_valid || last_grant == SRC_IC);
    grant_ic = ic_req_valid && !grant_dc;
  end

  assign ic_req_ready = reset && (state == IDLE) && grant_ic;
  assign dc_req_ready = reset && (state == IDLE) && grant_dc;
  assign ic_resp_data = resp_data;
  assign dc_resp_data = resp_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= SRC_IC;
      last_grant    <= SRC_IC;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_rw    <= 1'b0;
      mem_req_wdata <= '0;
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      resp_data     <= '0;
      err_spurious  <= 1'b0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      if (mem_resp_valid && state != WAIT)
        err_spurious <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_ic || grant_dc) begin
            mem_req_addr  <= grant_dc ? dc_req_addr  : ic_req_addr;
            mem_req_rw    <= grant_dc ? dc_req_rw    : ic_req_rw;
            mem_req_wdata <= grant_dc ? dc_req_wdata : ic_req_wdata;
            owner         <= grant_dc;
            last_grant    <= grant_dc;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            resp_data <= mem_resp_data;
            if (owner == SRC_DC)
              dc_resp_valid <= 1'b1;
            else
              ic_resp_valid <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a round-robin model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_req_rw, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [DW-1:0] ic_req_wdata, ic_resp_data;
  logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_wdata, dc_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_resp_valid, err_spurious;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_data;

  int tests = 0;
  int fails = 0;
  bit model_last_dc;
  bit reads_only;
  logic [DW-1:0] last_rd;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_req_rw(ic_req_rw), .ic_req_wdata(ic_req_wdata),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_rw(dc_req_rw), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_req(input bit dc, input bit v);
    logic [AW-1:0] a;
    a = $urandom & 32'hFFFF_FFF0;
    if (dc) begin
      dc_req_valid = v; dc_req_addr = a; dc_req_wdata = rnd_line();
      dc_req_rw = reads_only ? 1'b0 : 1'($urandom_range(0, 1));
    end else begin
      ic_req_valid = v; ic_req_addr = a; ic_req_wdata = rnd_line();
      ic_req_rw = reads_only ? 1'b0 : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst mem_req", {mem_req_valid, mem_req_rw, mem_req_addr}, '0);
    chk("rst mem_wdata", mem_req_wdata, '0);
    chk("rst resp_valid", {ic_resp_valid, dc_resp_valid}, '0);
    chk("rst resp_data", ic_resp_data | dc_resp_data, '0);
    chk("rst err", err_spurious, 1'b0);
    chk("rst ready", {ic_req_ready, dc_req_ready}, '0);
    reset = 1'b1;
    model_last_dc = 1'b0;
  endtask

  // Entered one tick after a posedge with the IDLE-cycle requests already driven.
  task automatic do_txn(input int mem_wait, input int resp_wait, input bit next_v,
                        input logic [DW-1:0] rdata, input string tag);
    bit            win_dc;
    logic [AW-1:0] ea;
    logic          erw;
    logic [DW-1:0] ewd;
    #1;
    win_dc = dc_req_valid && (!ic_req_valid || !model_last_dc);
    chk({tag, " ic_ready"}, ic_req_ready, ic_req_valid && !win_dc);
    chk({tag, " dc_ready"}, dc_req_ready, win_dc);
    ea  = win_dc ? dc_req_addr  : ic_req_addr;
    erw = win_dc ? dc_req_rw    : ic_req_rw;
    ewd = win_dc ? dc_req_wdata : ic_req_wdata;
    model_last_dc = win_dc;
    @(posedge clk); #1;
    new_req(win_dc, next_v);
    #1;
    chk({tag, " issue"}, {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, erw, ea});
    chk({tag, " wdata"}, mem_req_wdata, ewd);
    chk({tag, " resp idle"}, {ic_resp_valid, dc_resp_valid}, '0);
    for (int i = 0; i < mem_wait; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold"}, {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, erw, ea});
      chk({tag, " hold wdata"}, mem_req_wdata, ewd);
      chk({tag, " hold ready"}, {ic_req_ready, dc_req_ready}, '0);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk({tag, " wait valid"}, mem_req_valid, 1'b0);
    for (int i = 0; i < resp_wait; i++) begin
      @(posedge clk); #1;
      chk({tag, " wait resp"}, {ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready}, '0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = rdata;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    chk({tag, " route"}, {ic_resp_valid, dc_resp_valid}, {!win_dc, win_dc});
    if (!erw) begin
      chk({tag, " rdata"}, win_dc ? dc_resp_data : ic_resp_data, rdata);
      last_rd = rdata;
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    reset = 1'b0; reads_only = 1'b0;
    ic_req_valid = 1'b0; ic_req_rw = 1'b0; ic_req_addr = '0; ic_req_wdata = '0;
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0; dc_req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    do_reset();

    // icache read alone, immediate memory
    reads_only = 1'b1;
    new_req(0, 1);
    do_txn(0, 0, 0, {4{32'hA5A5A5A5}}, "t1");

    // dcache write held off by memory for 5 cycles while icache waits
    new_req(0, 1);
    reads_only = 1'b0;
    dc_req_valid = 1'b1; dc_req_addr = 32'h100; dc_req_rw = 1'b1; dc_req_wdata = rnd_line();
    do_txn(5, 1, 0, rnd_line(), "t3");
    d = rnd_line();
    do_txn(0, 0, 0, d, "t3b");

    // response outside WAIT is dropped and flagged
    @(posedge clk); #1;
    mem_resp_valid = 1'b1; mem_resp_data = ~d;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    chk("t4 resp_valid", {ic_resp_valid, dc_resp_valid}, '0);
    chk("t4 err", err_spurious, 1'b1);
    chk("t4 data hold", ic_resp_data, d);
    repeat (3) @(posedge clk);
    #1;
    chk("t4 err sticky", err_spurious, 1'b1);

    // reset during WAIT abandons the transaction
    do_reset();
    reads_only = 1'b1;
    new_req(0, 1);
    #1;
    chk("t5 accept", ic_req_ready, 1'b1);
    @(posedge clk); #1;
    ic_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    do_reset();
    mem_resp_valid = 1'b1; mem_resp_data = rnd_line();
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    chk("t5 late resp", {ic_resp_valid, dc_resp_valid}, '0);
    chk("t5 err", err_spurious, 1'b1);
    reads_only = 1'b0;
    new_req(1, 1);
    do_txn(0, 0, 0, rnd_line(), "t5b");

    // both requesting from the first cycle after reset: strict alternation
    do_reset();
    new_req(0, 1);
    new_req(1, 1);
    for (int i = 0; i < 8; i++)
      do_txn($urandom_range(0, 3), $urandom_range(0, 3), i < 6, rnd_line(), "t2");

    // back-to-back icache reads with zero-wait memory
    reads_only = 1'b1;
    new_req(0, 1);
    for (int i = 0; i < 4; i++)
      do_txn(0, 0, i < 3, rnd_line(), "t6");
    reads_only = 1'b0;

    // random mix of requesters, payloads and memory delays
    for (int i = 0; i < 24; i++) begin
      if (!ic_req_valid && !dc_req_valid)
        new_req(1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 2) == 0 && !ic_req_valid)
        new_req(0, 1);
      if ($urandom_range(0, 2) == 0 && !dc_req_valid)
        new_req(1, 1);
      do_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), rnd_line(), "rnd");
    end
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("end resp idle", {ic_resp_valid, dc_resp_valid, mem_req_valid}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
